cpu_bus_writer: RTL and testbench

Initiator on the controller BRAM port: turns register-update requests into timed 16-bit BRAM write and read-modify-write cycles. It is the write-side counterpart of `controller`, which only reads its parameter block (cycles, frequency divisors, sound speed, sync time, control register). Sits between the host-side command path and the controller BRAM. Replaces the bench-only BRAM write tasks in synthesizable logic, including the control-register bit set that triggers sync.

---
 rtl/cpu_bus_writer.sv | 180 ++++++++++++++++++
 tb/tb_cpu_bus_writer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_writer.sv
// cpu_bus_writer: BRAM-port initiator that turns host register-update requests
// into registered 16-bit burst writes and read-modify-write bit set/clear cycles.
module cpu_bus_writer #(
    parameter int ADDR_WIDTH = 14,
    parameter int RD_LATENCY = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [1:0]            REQ_OP,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [7:0]            REQ_LEN,
    input  logic [15:0]           REQ_MASK,
    input  logic                  DIN_VALID,
    output logic                  DIN_READY,
    input  logic [15:0]           DIN,
    output logic                  BUS_EN,
    output logic                  BUS_WE,
    output logic [ADDR_WIDTH-1:0] BUS_ADDR,
    output logic [15:0]           BUS_DOUT,
    input  logic [15:0]           BUS_DIN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
    output logic [2:0]            DBG_STATE
);

    // Handshakes (REQ and DIN): a transfer happens on the CLK edge where VALID
    // and READY are both 1. READY is a function of state only, never of VALID,
    // and VALID may be raised or dropped at any time without a penalty.

    localparam logic [1:0] OP_BURST = 2'd0;
    localparam logic [1:0] OP_SET   = 2'd1;
    localparam logic [1:0] OP_CLR   = 2'd2;

    localparam logic [2:0] WAIT_LAST = 3'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_BURST    = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RMW_WR   = 3'd4,
        S_FIN      = 3'd5,
        S_RSV      = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [15:0]           mask_q, mask_d;
    logic                  clr_q, clr_d;
    logic [2:0]            wait_q, wait_d;

    logic                  bus_en_q, bus_en_d;
    logic                  bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [15:0]           bus_dout_q, bus_dout_d;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            mask_q     <= '0;
            clr_q      <= 1'b0;
            wait_q     <= '0;
            bus_en_q   <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_dout_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            clr_q      <= clr_d;
            wait_q     <= wait_d;
            bus_en_q   <= bus_en_d;
            bus_we_q   <= bus_we_d;
            bus_addr_q <= bus_addr_d;
            bus_dout_q <= bus_dout_d;
        end
    end

    // Bus cycles are scheduled on the transition into the state that owns
    // them, so the registered bus outputs line up with that state.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        clr_d      = clr_q;
        wait_d     = wait_q;
        bus_en_d   = 1'b0;
        bus_we_d   = 1'b0;
        bus_addr_d = bus_addr_q;
        bus_dout_d = bus_dout_q;

        case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    case (REQ_OP)
                        OP_BURST: begin
                            addr_d  = REQ_ADDR;
                            len_d   = REQ_LEN;
                            cnt_d   = '0;
                            state_d = (REQ_LEN == 8'd0) ? S_FIN : S_BURST;
                        end
                        OP_SET, OP_CLR: begin
                            addr_d     = REQ_ADDR;
                            mask_d     = REQ_MASK;
                            clr_d      = (REQ_OP == OP_CLR);
                            bus_en_d   = 1'b1;
                            bus_addr_d = REQ_ADDR;
                            state_d    = S_RD_ISSUE;
                        end
                        default: state_d = S_RSV;
                    endcase
                end
            end

            S_BURST: begin
                if (DIN_VALID) begin
                    bus_en_d   = 1'b1;
                    bus_we_d   = 1'b1;
                    bus_addr_d = addr_q;
                    bus_dout_d = DIN;
                    addr_d     = addr_q + ADDR_WIDTH'(1);
                    cnt_d      = cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) begin
                        state_d = S_FIN;
                    end
                end
            end

            S_RD_ISSUE: begin
                wait_d  = '0;
                state_d = S_RD_WAIT;
            end

            // Read data is valid in the last RD_WAIT cycle; it feeds the
            // write-back register directly instead of a separate capture stage.
            S_RD_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    bus_en_d   = 1'b1;
                    bus_we_d   = 1'b1;
                    bus_addr_d = addr_q;
                    bus_dout_d = clr_q ? (BUS_DIN & ~mask_q) : (BUS_DIN | mask_q);
                    state_d    = S_RMW_WR;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end

            S_RMW_WR: state_d = S_FIN;
            S_FIN:    state_d = S_IDLE;
            S_RSV:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign REQ_READY = (state_q == S_IDLE);
    assign DIN_READY = (state_q == S_BURST);
    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = (state_q == S_FIN);
    assign ERR       = (state_q == S_RSV);
    assign DBG_STATE = state_q;

    assign BUS_EN   = bus_en_q;
    assign BUS_WE   = bus_we_q;
    assign BUS_ADDR = bus_addr_q;
    assign BUS_DOUT = bus_dout_q;

endmodule

// File: tb/tb_cpu_bus_writer.sv
// tb_cpu_bus_writer: scenario tasks for cpu_bus_writer against a behavioural
// BRAM and a request-level model of expected bus cycles, DONE and ERR pulses.
module tb_cpu_bus_writer;
  localparam int AW = 14;
  localparam int RD_LAT = 2;
  localparam int W = 64;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic REQ_VALID = 1'b0;
  logic REQ_READY;
  logic [1:0] REQ_OP = 2'd0;
  logic [AW-1:0] REQ_ADDR = '0;
  logic [7:0] REQ_LEN = 8'd0;
  logic [15:0] REQ_MASK = 16'd0;
  logic DIN_VALID = 1'b0;
  logic DIN_READY;
  logic [15:0] DIN = 16'd0;
  logic BUS_EN, BUS_WE;
  logic [AW-1:0] BUS_ADDR;
  logic [15:0] BUS_DOUT, BUS_DIN;
  logic BUSY, DONE, ERR;
  logic [2:0] DBG_STATE;

  cpu_bus_writer #(.ADDR_WIDTH(AW), .RD_LATENCY(RD_LAT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN), .REQ_MASK(REQ_MASK),
    .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY), .DIN(DIN),
    .BUS_EN(BUS_EN), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
    .BUS_DOUT(BUS_DOUT), .BUS_DIN(BUS_DIN),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .DBG_STATE(DBG_STATE)
  );

  // clock / reset / cycle counter
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // behavioural BRAM: read data valid RD_LAT cycles after the read cycle
  logic [15:0] mem [0:(1<<AW)-1];
  logic [15:0] rd_pipe [0:RD_LAT-1];
  logic pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [15:0] pre_data = 16'd0;
  always @(posedge CLK) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (BUS_EN === 1'b1 && BUS_WE === 1'b1) mem[BUS_ADDR] <= BUS_DOUT;
    rd_pipe[0] <= (BUS_EN === 1'b1 && BUS_WE === 1'b0) ? mem[BUS_ADDR] : 16'hDEAD;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign BUS_DIN = rd_pipe[RD_LAT-1];

  // scoreboard state
  int n_checks = 0;
  int n_pass = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int done_q[$], err_q[$], exp_done[$], exp_err[$];
  logic [15:0] wr_q[$];
  int gap_q[$];
  int hs_q[$];
  logic [15:0] ref_mem [int];

  function automatic logic [W-1:0] ev(input int c, input logic we, input logic [AW-1:0] a, input logic [15:0] d);
    logic [31:0] cc;
    cc = c;
    return {cc[15:0], 15'd0, we, 2'b00, a, d};
  endfunction

  // monitor: every bus cycle, DONE and ERR pulse, stamped with its cycle
  always @(negedge CLK) begin
    if (BUS_EN === 1'b1) obs_q.push_back(ev(cyc, BUS_WE, BUS_ADDR, (BUS_WE === 1'b1) ? BUS_DOUT : 16'd0));
    if (DONE === 1'b1) done_q.push_back(cyc);
    if (ERR === 1'b1) err_q.push_back(cyc);
  end

  // driver tasks
  task automatic issue_req(input logic [1:0] op, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [15:0] mask, input bit hold, output int t0);
    bit ok;
    ok = 0;
    t0 = -100;
    REQ_OP = op; REQ_ADDR = addr; REQ_LEN = len; REQ_MASK = mask; REQ_VALID = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if (REQ_READY === 1'b1) begin t0 = cyc; ok = 1; end
      @(posedge CLK); #1;
    end
    if (!hold) REQ_VALID = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL req_accept: REQ_READY=%b, not seen high within 40 cycles, want 1", REQ_READY);
    else n_pass++;
  endtask

  task automatic send_words();
    bit ok;
    hs_q.delete();
    for (int k = 0; k < wr_q.size(); k++) begin
      DIN_VALID = 1'b0;
      for (int g = 0; g < gap_q[k]; g++) begin @(posedge CLK); #1; end
      DIN_VALID = 1'b1; DIN = wr_q[k]; ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
        @(negedge CLK);
        if (DIN_READY === 1'b1) begin hs_q.push_back(cyc); ok = 1; end
        @(posedge CLK); #1;
      end
      n_checks++;
      if (!ok) begin
        $display("FAIL din_accept: word %0d DIN_READY=%b within 40 cycles, want 1", k, DIN_READY);
        DIN_VALID = 1'b0;
        return;
      end
      n_pass++;
    end
    DIN_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if (REQ_READY === 1'b1) ok = 1;
      @(posedge CLK); #1;
    end
    n_checks++;
    if (!ok) $display("FAIL idle_timeout: REQ_READY=%b after 40 cycles, want 1", REQ_READY);
    else n_pass++;
  endtask

  task automatic preload(input logic [AW-1:0] addr, input logic [15:0] data);
    pre_addr = addr; pre_data = data; pre_we = 1'b1;
    @(posedge CLK); #1;
    pre_we = 1'b0;
    ref_mem[int'(addr)] = data;
  endtask

  // model: word k of a burst lands at base+k (mod 2^AW) one cycle after its handshake
  task automatic expect_burst(input logic [AW-1:0] base);
    for (int k = 0; k < hs_q.size(); k++) begin
      logic [AW-1:0] a;
      a = base + AW'(k);
      exp_q.push_back(ev(hs_q[k] + 1, 1'b1, a, wr_q[k]));
      ref_mem[int'(a)] = wr_q[k];
    end
    if (hs_q.size() > 0) exp_done.push_back(hs_q[hs_q.size()-1] + 1);
  endtask

  // model: read at t0+1, write of the modified word at t0+2+RD_LAT, DONE one later
  task automatic expect_rmw(input int t0, input bit clr, input logic [AW-1:0] a, input logic [15:0] mask);
    logic [15:0] nv;
    nv = clr ? (ref_mem[int'(a)] & ~mask) : (ref_mem[int'(a)] | mask);
    exp_q.push_back(ev(t0 + 1, 1'b0, a, 16'd0));
    exp_q.push_back(ev(t0 + 2 + RD_LAT, 1'b1, a, nv));
    exp_done.push_back(t0 + 3 + RD_LAT);
    ref_mem[int'(a)] = nv;
  endtask

  // scenarios
  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    @(negedge CLK);
    n_checks++; if (REQ_READY !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", REQ_READY); else n_pass++;
    n_checks++; if (DIN_READY !== 1'b0) $display("FAIL reset_din_ready: got %b want 0", DIN_READY); else n_pass++;
    n_checks++; if ({BUS_EN, BUS_WE} !== 2'b00) $display("FAIL reset_bus_en_we: got %b want 00", {BUS_EN, BUS_WE}); else n_pass++;
    n_checks++; if ({BUSY, DONE, ERR} !== 3'b000) $display("FAIL reset_busy_done_err: got %b want 000", {BUSY, DONE, ERR}); else n_pass++;
    n_checks++; if (BUS_ADDR !== '0) $display("FAIL reset_bus_addr: got %h want 0", BUS_ADDR); else n_pass++;
    n_checks++; if (BUS_DOUT !== 16'd0) $display("FAIL reset_bus_dout: got %h want 0", BUS_DOUT); else n_pass++;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_burst();
    int t0;
    wr_q = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    gap_q = '{0, 0, 0, 0};
    issue_req(2'd0, 14'h0010, 8'd4, 16'h0000, 1'b0, t0);
    send_words();
    n_checks++;
    if (hs_q.size() != 4 || hs_q[0] != t0 + 1 || hs_q[3] != t0 + 4)
      $display("FAIL burst_din_timing: got %0d handshakes first at t0+%0d, want 4 at t0+1..t0+4", hs_q.size(), hs_q[0] - t0);
    else n_pass++;
    @(negedge CLK);
    n_checks++; if ({DONE, REQ_READY} !== 2'b10) $display("FAIL burst_done: got DONE,REQ_READY=%b want 10", {DONE, REQ_READY}); else n_pass++;
    @(negedge CLK);
    n_checks++; if ({DONE, REQ_READY} !== 2'b01) $display("FAIL burst_ready_back: got DONE,REQ_READY=%b want 01", {DONE, REQ_READY}); else n_pass++;
    expect_burst(14'h0010);
    @(posedge CLK); #1;
  endtask

  task automatic test_stall_wrap();
    int t0;
    wr_q = '{16'($urandom), 16'($urandom), 16'($urandom)};
    gap_q = '{0, 1, 1};
    issue_req(2'd0, 14'h3FFE, 8'd3, 16'h0000, 1'b0, t0);
    send_words();
    n_checks++;
    if (hs_q.size() != 3 || hs_q[0] != t0 + 1 || hs_q[1] != t0 + 3 || hs_q[2] != t0 + 5)
      $display("FAIL stall_din_timing: got %0d handshakes, last at t0+%0d, want 3 at t0+1,3,5", hs_q.size(), hs_q[2] - t0);
    else n_pass++;
    @(negedge CLK);
    n_checks++; if (DONE !== 1'b1) $display("FAIL stall_done: got %b want 1", DONE); else n_pass++;
    expect_burst(14'h3FFE);
    wait_idle();
  endtask

  task automatic test_rmw_set();
    int t0;
    preload(14'h0000, 16'h0100);
    issue_req(2'd1, 14'h0000, 8'd0, 16'h0001, 1'b0, t0);
    @(negedge CLK);
    n_checks++;
    if ({BUS_EN, BUS_WE, BUSY} !== 3'b101 || BUS_ADDR !== 14'h0000)
      $display("FAIL set_read_cycle: got EN,WE,BUSY=%b addr %h want 101 addr 0000", {BUS_EN, BUS_WE, BUSY}, BUS_ADDR);
    else n_pass++;
    while (cyc < t0 + 2 + RD_LAT) @(negedge CLK);
    n_checks++;
    if ({BUS_EN, BUS_WE} !== 2'b11 || BUS_DOUT !== 16'h0101)
      $display("FAIL set_write_cycle: got EN,WE=%b data %h want 11 data 0101", {BUS_EN, BUS_WE}, BUS_DOUT);
    else n_pass++;
    @(negedge CLK);
    n_checks++; if ({DONE, REQ_READY} !== 2'b10) $display("FAIL set_done: got DONE,REQ_READY=%b want 10", {DONE, REQ_READY}); else n_pass++;
    @(negedge CLK);
    n_checks++; if ({DONE, REQ_READY} !== 2'b01) $display("FAIL set_ready_back: got DONE,REQ_READY=%b want 01", {DONE, REQ_READY}); else n_pass++;
    expect_rmw(t0, 1'b0, 14'h0000, 16'h0001);
    @(posedge CLK); #1;
  endtask

  task automatic test_rmw_clear_held();
    int t0, t1;
    logic [15:0] m2;
    m2 = 16'($urandom);
    preload(14'h0123, 16'hFFFF);
    preload(14'h0456, 16'($urandom));
    issue_req(2'd2, 14'h0123, 8'd0, 16'h8001, 1'b1, t0);
    issue_req(2'd1, 14'h0456, 8'd0, m2, 1'b0, t1);
    n_checks++;
    if (t1 != t0 + 4 + RD_LAT) $display("FAIL held_req_accept: got t0+%0d want t0+%0d", t1 - t0, 4 + RD_LAT);
    else n_pass++;
    expect_rmw(t0, 1'b1, 14'h0123, 16'h8001);
    expect_rmw(t1, 1'b0, 14'h0456, m2);
    wait_idle();
    n_checks++; if (mem[14'h0123] !== 16'h7FFE) $display("FAIL clear_result: got %h want 7ffe", mem[14'h0123]); else n_pass++;
  endtask

  task automatic test_len0_rsv();
    int t0;
    issue_req(2'd0, 14'h0055, 8'd0, 16'hFFFF, 1'b0, t0);
    @(negedge CLK);
    n_checks++; if ({DONE, BUS_EN} !== 2'b10) $display("FAIL len0_done: got DONE,BUS_EN=%b want 10", {DONE, BUS_EN}); else n_pass++;
    @(negedge CLK);
    n_checks++; if (REQ_READY !== 1'b1) $display("FAIL len0_ready_back: got %b want 1", REQ_READY); else n_pass++;
    exp_done.push_back(t0 + 1);
    @(posedge CLK); #1;
    issue_req(2'd3, 14'h0066, 8'd5, 16'h1234, 1'b0, t0);
    @(negedge CLK);
    n_checks++; if ({ERR, DONE, BUS_EN} !== 3'b100) $display("FAIL rsv_err: got ERR,DONE,BUS_EN=%b want 100", {ERR, DONE, BUS_EN}); else n_pass++;
    exp_err.push_back(t0 + 1);
    wait_idle();
  endtask

  task automatic test_reset_mid_burst();
    int t0;
    logic [15:0] w0, w1;
    w0 = 16'($urandom); w1 = 16'($urandom);
    issue_req(2'd0, 14'h0200, 8'd8, 16'h0000, 1'b0, t0);
    DIN_VALID = 1'b1; DIN = w0;
    @(negedge CLK);
    n_checks++; if (DIN_READY !== 1'b1) $display("FAIL rst_first_word: DIN_READY got %b want 1", DIN_READY); else n_pass++;
    @(posedge CLK); #1;
    DIN = w1; RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({REQ_READY, DIN_READY, BUS_EN, BUS_WE, BUSY, DONE, ERR} !== 7'b1000000 || BUS_ADDR !== '0 || BUS_DOUT !== 16'd0)
      $display("FAIL rst_mid_outputs: got %b addr %h dout %h want 1000000 addr 0 dout 0",
               {REQ_READY, DIN_READY, BUS_EN, BUS_WE, BUSY, DONE, ERR}, BUS_ADDR, BUS_DOUT);
    else n_pass++;
    repeat (4) begin @(posedge CLK); #1; end
    DIN_VALID = 1'b0;
    exp_q.push_back(ev(t0 + 2, 1'b1, 14'h0200, w0));
    ref_mem[32'h200] = w0;
    wr_q = '{16'($urandom)};
    gap_q = '{0};
    issue_req(2'd0, 14'h0300, 8'd1, 16'h0000, 1'b0, t0);
    send_words();
    expect_burst(14'h0300);
    wait_idle();
  endtask

  task automatic test_random();
    int t0, r, len;
    logic [AW-1:0] addr;
    logic [15:0] mask;
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 9);
      addr = AW'($urandom_range(0, (1 << AW) - 1));
      mask = 16'($urandom);
      if (r < 5) begin
        len = $urandom_range(0, 6);
        wr_q.delete(); gap_q.delete();
        for (int k = 0; k < len; k++) begin
          wr_q.push_back(16'($urandom));
          gap_q.push_back($urandom_range(0, 2));
        end
        issue_req(2'd0, addr, 8'(len), mask, 1'b0, t0);
        if (len > 0) begin
          send_words();
          expect_burst(addr);
        end else exp_done.push_back(t0 + 1);
      end else if (r < 9) begin
        preload(addr, 16'($urandom));
        issue_req((r < 7) ? 2'd1 : 2'd2, addr, 8'($urandom_range(0, 255)), mask, 1'b0, t0);
        expect_rmw(t0, (r >= 7), addr, mask);
      end else begin
        issue_req(2'd3, addr, 8'($urandom_range(0, 255)), mask, 1'b0, t0);
        exp_err.push_back(t0 + 1);
      end
      wait_idle();
    end
  endtask

  task automatic test_scoreboard();
    logic [W-1:0] got;
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL bus_cycle_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      n_checks++;
      if (got !== exp_q[i]) $display("FAIL bus_cycle[%0d]: got %h want %h (cyc|we|addr|data)", i, got, exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (done_q != exp_done) $display("FAIL done_pulses: got %0d pulses want %0d (or cycles differ)", done_q.size(), exp_done.size());
    else n_pass++;
    n_checks++;
    if (err_q != exp_err) $display("FAIL err_pulses: got %0d pulses want %0d (or cycles differ)", err_q.size(), exp_err.size());
    else n_pass++;
    foreach (ref_mem[a]) begin
      n_checks++;
      if (mem[a] !== ref_mem[a]) $display("FAIL mem[%h]: got %h want %h", a, mem[a], ref_mem[a]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_stall_wrap();
    test_rmw_set();
    test_rmw_clear_held();
    test_len0_rsv();
    test_reset_mid_burst();
    test_random();
    repeat (3) begin @(posedge CLK); #1; end
    test_scoreboard();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
